// File: rtl/pwm_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_multi_if : configuration handshake bundle for pwm_multi                |
// | Optional macro: PWM_DEADTIME_EN adds the dead_time_i field.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pwm_multi_if #(
  parameter int WIDTH = 32,
  parameter int N_CH  = 4
`ifdef PWM_DEADTIME_EN
  , parameter int DT_W = 8
`endif
);
  logic                  cfg_valid_i;
  logic                  cfg_ready_o;
  logic [WIDTH-1:0]      incr_i;
  logic [N_CH*WIDTH-1:0] duty_i;
  logic [N_CH*WIDTH-1:0] phase_i;
  logic [N_CH-1:0]       en_i;
`ifdef PWM_DEADTIME_EN
  logic [DT_W-1:0]       dead_time_i;
`endif

  modport master (
    input  cfg_ready_o,
`ifdef PWM_DEADTIME_EN
    output dead_time_i,
`endif
    output cfg_valid_i, incr_i, duty_i, phase_i, en_i
  );

  modport slave (
    output cfg_ready_o,
`ifdef PWM_DEADTIME_EN
    input  dead_time_i,
`endif
    input  cfg_valid_i, incr_i, duty_i, phase_i, en_i
  );
endinterface
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_multi : N-channel PWM sharing one phase accumulator, double-buffered   |
// | config applied at accumulator wrap. Optional macro: PWM_DEADTIME_EN        |
// | (complementary outputs with dead-time insertion).                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pwm_multi #(
  parameter int WIDTH = 32,
  parameter int N_CH  = 4
`ifdef PWM_DEADTIME_EN
  , parameter int DT_W = 8
`endif
) (
  input  wire             clk,
  input  wire             resetn,
  pwm_multi_if.slave      cfg,
  output logic [N_CH-1:0] pwm_o,
`ifdef PWM_DEADTIME_EN
  output logic [N_CH-1:0] pwm_n_o,
`endif
  output logic            wrap_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_apply;

  logic [WIDTH-1:0]      r_acc;
  logic [WIDTH-1:0]      r_incr_act;
  logic [WIDTH-1:0]      r_incr_shd;
  logic [N_CH*WIDTH-1:0] r_duty_act;
  logic [N_CH*WIDTH-1:0] r_duty_shd;
  logic [N_CH*WIDTH-1:0] r_phase_act;
  logic [N_CH*WIDTH-1:0] r_phase_shd;
  logic [N_CH-1:0]       r_en_act;
  logic [N_CH-1:0]       r_en_shd;
  logic                  r_wrap;

  logic [WIDTH:0]        w_acc_sum;
  logic                  w_wrap;
  logic [N_CH-1:0]       w_raw;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_incr_act};
  assign w_wrap    = w_acc_sum[WIDTH];

  // With incr_act==0 no wrap can ever come, so a pending update goes in at once.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg.cfg_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_wrap || (r_incr_act == '0)) begin
          w_apply     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign cfg.cfg_ready_o = (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_wrap      <= 1'b0;
      r_incr_act  <= '0;
      r_duty_act  <= '0;
      r_phase_act <= '0;
      r_en_act    <= '0;
      r_incr_shd  <= '0;
      r_duty_shd  <= '0;
      r_phase_shd <= '0;
      r_en_shd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_sum[WIDTH-1:0];
      r_wrap  <= w_wrap;
      if (w_accept) begin
        r_incr_shd  <= cfg.incr_i;
        r_duty_shd  <= cfg.duty_i;
        r_phase_shd <= cfg.phase_i;
        r_en_shd    <= cfg.en_i;
      end
      if (w_apply) begin
        r_incr_act  <= r_incr_shd;
        r_duty_act  <= r_duty_shd;
        r_phase_act <= r_phase_shd;
        r_en_act    <= r_en_shd;
      end
    end
  end

  assign wrap_o = r_wrap;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [WIDTH-1:0] w_cnt;
    assign w_cnt    = r_acc + r_phase_act[k*WIDTH +: WIDTH];
    assign w_raw[k] = r_en_act[k] & (w_cnt < r_duty_act[k*WIDTH +: WIDTH]);
  end

`ifdef PWM_DEADTIME_EN
  // Any raw edge drops both outputs; the new side is released once the counter expires.
  for (genvar k = 0; k < N_CH; k++) begin : g_dt
    logic            r_prev;
    logic            r_p;
    logic            r_n;
    logic [DT_W-1:0] r_dt_cnt;
    logic            w_tgt_p;
    logic            w_tgt_n;

    assign w_tgt_p = w_raw[k];
    assign w_tgt_n = r_en_act[k] & ~w_raw[k];

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_prev   <= 1'b0;
        r_p      <= 1'b0;
        r_n      <= 1'b0;
        r_dt_cnt <= '0;
      end else begin
        r_prev <= w_raw[k];
        if (w_raw[k] != r_prev) begin
          r_dt_cnt <= cfg.dead_time_i;
          if (cfg.dead_time_i == '0) begin
            r_p <= w_tgt_p;
            r_n <= w_tgt_n;
          end else begin
            r_p <= 1'b0;
            r_n <= 1'b0;
          end
        end else if (r_dt_cnt != '0) begin
          r_dt_cnt <= r_dt_cnt - DT_W'(1);
          if (r_dt_cnt == DT_W'(1)) begin
            r_p <= w_tgt_p;
            r_n <= w_tgt_n;
          end
        end else begin
          r_p <= w_tgt_p;
          r_n <= w_tgt_n;
        end
      end
    end

    assign pwm_o[k]   = r_p;
    assign pwm_n_o[k] = r_n;
  end
`else
  logic [N_CH-1:0] r_pwm;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_raw;
    end
  end

  assign pwm_o = r_pwm;
`endif

endmodule
`default_nettype wire
